ascon_perm_iter: RTL and testbench
==================================

ASCON_PERM_ITER -- requirements
Module: ascon_perm_iter

Interface
REQ-001 Parameter UNROLL, default 1, rounds computed per clock cycle; legal values 1 to 4.
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port in_valid  input  1  state_in and nr_in are valid.
REQ-005 Port in_ready  output  1  block can accept a new permutation request.
REQ-006 Port nr_in  input  5  round count for this request, 0 to 16.
REQ-007 Port state_in  input  ascon_state (320)  state before permutation, fields s0..s4.
REQ-008 Port out_valid  output  1  state_out holds a completed permutation result.
REQ-009 Port out_ready  input  1  consumer accepts state_out.
REQ-010 Port state_out  output  ascon_state (320)  permuted state.
REQ-011 Port busy  output  1  high in RUN or DONE.

Function
REQ-012 Round = pc, then ps, then pl; pc XORs const_add[idx] into s2 only, leaving s0, s1, s3 and s4 unchanged.
REQ-013 Round i (0-based) of an nr-round permutation uses idx = 16 - nr + i, 4-bit; p12 uses idx 4..15, p8 uses 8..15, p6 uses 10..15.
REQ-014 ps is the Ascon 5-bit S-box applied bitsliced across all 64 columns; pl is per word: s0 ^= ror19 ^ ror28, s1 ^= ror61 ^ ror39, s2 ^= ror1 ^ ror6, s3 ^= ror10 ^ ror17, s4 ^= ror7 ^ ror41.
REQ-015 FSM states: IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE: on in_valid && in_ready, register state_in into the working state, set rounds_left = nr_in and idx = 16 - nr_in, then go to RUN (nr_in > 0) or DONE (nr_in = 0, state passed through unchanged).
REQ-017 RUN: each cycle apply k = min(UNROLL, rounds_left) chained rounds with consecutive idx, then rounds_left -= k and idx += k; go to DONE when rounds_left reaches 0.
REQ-018 When rounds_left < UNROLL, the unused unrolled stages are bypassed; the result is identical to UNROLL = 1.
REQ-019 Latency: accept to first out_valid cycle = ceil(nr/UNROLL) cycles for nr > 0, and 1 cycle for nr = 0.
REQ-020 DONE: state_out is driven from the working register and held stable while out_valid && !out_ready; on out_ready go to IDLE.
REQ-021 No new request is accepted in the out_ready handshake cycle; in_ready rises the following cycle.
REQ-022 nr_in values 17 to 31 are clamped to 16.
REQ-023 Inputs are ignored outside IDLE; state_in and nr_in need not be held after acceptance.
REQ-024 state_out is don't-care-free: it always equals the working register, including during RUN.

Reset
REQ-025 rst high at a clock edge: FSM to IDLE, working state to all zeros, rounds_left = 0, idx = 0.
REQ-026 During reset and in the first cycle after it, out_valid = 0 and busy = 0; state_out = 0; in_ready = 1 from the first cycle after rst is deasserted.
REQ-027 Reset mid-RUN or mid-DONE aborts the operation; no out_valid pulse for the aborted request.

Verification
REQ-028 UNROLL=1, nr_in=12, state_in random, out_ready=1 -> out_valid exactly 12 cycles after acceptance; state_out matches the golden Ascon p12 model.
REQ-029 UNROLL=4, nr_in=6 -> out_valid after 2 cycles (4+2 rounds); nr_in=8 -> 2 cycles; nr_in=12 -> 3 cycles; all results bit-exact versus an UNROLL=1 run on the same inputs.
REQ-030 nr_in=0, state_in=0x0123..pattern -> out_valid after 1 cycle; state_out equals state_in exactly.
REQ-031 nr_in=1, state_in all zero -> result equals a single model round using const_add[15] (0x4b in s2 before ps); nr_in=16 uses idx 0..15.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> state_out stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-033 Assert rst in RUN cycle 3 of p12 -> next cycle IDLE, out_valid=0, state_out=0; a new p8 request then completes correctly.

Source files
------------

// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation: a valid/ready request carries a state and a round count (0..16).
// UNROLL chained rounds run per clock; rounds beyond the remaining count are bypassed.
package ascon_perm_iter_pkg;
  typedef struct packed {
    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] s3;
    logic [63:0] s4;
  } ascon_state_t;
endpackage

module ascon_perm_iter
  import ascon_perm_iter_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   nr_in,
  input  ascon_state_t state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output ascon_state_t state_out,
  output logic         busy
);

  localparam int STAGES = (UNROLL < 1) ? 1 : ((UNROLL > 4) ? 4 : UNROLL);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm_reg;
  ascon_state_t work_reg;
  logic [4:0]   rounds_left_reg;
  logic [3:0]   idx_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;
  logic         busy_reg;

  logic [4:0]   nr_clamped;
  logic [3:0]   idx_start;
  logic [4:0]   step;
  ascon_state_t chain_out;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Constants for idx 0..15 follow 0x3c, 0x2d, ... 0x0f, 0xf0, ... 0x4b:
  // the high nibble counts down from 3 and the low nibble up from 0xc, both mod 16.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'd3 - idx;
    lo = 4'd12 + idx;
    return {hi, lo};
  endfunction

  function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    ascon_state_t r;
    x0 = s.s0;
    x1 = s.s1;
    x2 = s.s2 ^ {56'd0, round_const(idx)};
    x3 = s.s3;
    x4 = s.s4;
    // Bitsliced 5-bit S-box across all 64 columns.
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    r.s0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    r.s1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    r.s2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    r.s3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    r.s4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return r;
  endfunction

  assign nr_clamped = (nr_in > 5'd16) ? 5'd16 : nr_in;
  // 16 - nr modulo 16; nr = 0 never runs a round, so its wrapped index is irrelevant.
  assign idx_start  = 4'd0 - nr_clamped[3:0];
  assign step       = (rounds_left_reg < 5'(STAGES)) ? rounds_left_reg : 5'(STAGES);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    ascon_state_t s_in;
    ascon_state_t s_out;
    logic [3:0]   s_idx;
    if (gi == 0) begin : g_first
      assign s_in = work_reg;
    end else begin : g_next
      assign s_in = g_stage[gi-1].s_out;
    end
    assign s_idx = idx_reg + 4'(gi);
    // Stages past the remaining round count pass their input straight through.
    assign s_out = (rounds_left_reg > 5'(gi)) ? ascon_round(s_in, s_idx) : s_in;
  end

  assign chain_out = g_stage[STAGES-1].s_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg         <= IDLE;
      work_reg        <= '0;
      rounds_left_reg <= '0;
      idx_reg         <= '0;
      in_ready_reg    <= 1'b1;
      out_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg        <= state_in;
            rounds_left_reg <= nr_clamped;
            idx_reg         <= idx_start;
            in_ready_reg    <= 1'b0;
            busy_reg        <= 1'b1;
            if (nr_clamped == 5'd0) begin
              fsm_reg       <= DONE;
              out_valid_reg <= 1'b1;
            end else begin
              fsm_reg       <= RUN;
            end
          end
        end
        RUN: begin
          work_reg        <= chain_out;
          rounds_left_reg <= rounds_left_reg - step;
          idx_reg         <= idx_reg + step[3:0];
          if (rounds_left_reg == step) begin
            fsm_reg       <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_reg       <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          fsm_reg       <= IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign state_out = work_reg;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Drives UNROLL=1..4 instances with shared requests and checks each against a
// column-wise S-box-table model of the Ascon permutation every cycle.
module tb_ascon_perm_iter;
  import ascon_perm_iter_pkg::*;

  localparam int NU = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [4:0]   nr_in;
  ascon_state_t state_in;

  logic         in_ready_w  [NU];
  logic         out_valid_w [NU];
  logic         busy_w      [NU];
  ascon_state_t state_out_w [NU];

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NU; gi++) begin : g_dut
    ascon_perm_iter #(.UNROLL(gi + 1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[gi]),
      .nr_in     (nr_in),
      .state_in  (state_in),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready),
      .state_out (state_out_w[gi]),
      .busy      (busy_w[gi])
    );
  end

  task automatic chk(input string name, input int u, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s unroll=%0d t=%0t actual=%h required=%h", name, u + 1, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rc(input int idx);
    case (idx)
      0: return 8'h3c;   1: return 8'h2d;   2: return 8'h1e;   3: return 8'h0f;
      4: return 8'hf0;   5: return 8'he1;   6: return 8'hd2;   7: return 8'hc3;
      8: return 8'hb4;   9: return 8'ha5;  10: return 8'h96;  11: return 8'h87;
      12: return 8'h78; 13: return 8'h69;  14: return 8'h5a;  15: return 8'h4b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [4:0] sbox5(input logic [4:0] v);
    case (v)
      5'd0:  return 5'h04; 5'd1:  return 5'h0b; 5'd2:  return 5'h1f; 5'd3:  return 5'h14;
      5'd4:  return 5'h1a; 5'd5:  return 5'h15; 5'd6:  return 5'h09; 5'd7:  return 5'h02;
      5'd8:  return 5'h1b; 5'd9:  return 5'h05; 5'd10: return 5'h08; 5'd11: return 5'h12;
      5'd12: return 5'h1d; 5'd13: return 5'h03; 5'd14: return 5'h06; 5'd15: return 5'h1c;
      5'd16: return 5'h1e; 5'd17: return 5'h13; 5'd18: return 5'h07; 5'd19: return 5'h0e;
      5'd20: return 5'h00; 5'd21: return 5'h0d; 5'd22: return 5'h11; 5'd23: return 5'h18;
      5'd24: return 5'h10; 5'd25: return 5'h0c; 5'd26: return 5'h01; 5'd27: return 5'h19;
      5'd28: return 5'h16; 5'd29: return 5'h0a; 5'd30: return 5'h0f; default: return 5'h17;
    endcase
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r);
    logic [127:0] d;
    d = {x, x} >> r;
    return d[63:0];
  endfunction

  function automatic ascon_state_t model_round(input ascon_state_t s, input int idx);
    logic [63:0] w [5];
    logic [63:0] n [5];
    logic [4:0]  v;
    logic [4:0]  o;
    ascon_state_t r;
    w[0] = s.s0; w[1] = s.s1; w[2] = s.s2 ^ {56'd0, rc(idx)}; w[3] = s.s3; w[4] = s.s4;
    for (int c = 0; c < 64; c++) begin
      v = {w[0][c], w[1][c], w[2][c], w[3][c], w[4][c]};
      o = sbox5(v);
      n[0][c] = o[4]; n[1][c] = o[3]; n[2][c] = o[2]; n[3][c] = o[1]; n[4][c] = o[0];
    end
    r.s0 = n[0] ^ rotr(n[0], 19) ^ rotr(n[0], 28);
    r.s1 = n[1] ^ rotr(n[1], 61) ^ rotr(n[1], 39);
    r.s2 = n[2] ^ rotr(n[2], 1)  ^ rotr(n[2], 6);
    r.s3 = n[3] ^ rotr(n[3], 10) ^ rotr(n[3], 17);
    r.s4 = n[4] ^ rotr(n[4], 7)  ^ rotr(n[4], 41);
    return r;
  endfunction

  // First `count` rounds of an nr-round permutation.
  function automatic ascon_state_t model_perm(input ascon_state_t s, input int nr, input int count);
    ascon_state_t t;
    t = s;
    for (int i = 0; i < count; i++) t = model_round(t, 16 - nr + i);
    return t;
  endfunction

  function automatic ascon_state_t rand_state();
    ascon_state_t s;
    s = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return s;
  endfunction

  // Per-instance expectation: phase 0 idle, 1 running, 2 result offered.
  int           m_phase [NU];
  int           m_nr    [NU];
  int           m_done  [NU];
  ascon_state_t m_base  [NU];
  ascon_state_t m_cur   [NU];
  bit           m_live = 1'b0;

  initial forever begin
    @(posedge clk);
    for (int u = 0; u < NU; u++) begin
      if (rst) begin
        m_phase[u] = 0;
        m_cur[u]   = '0;
      end else begin
        case (m_phase[u])
          0: if (in_valid) begin
            m_nr[u]    = (nr_in > 5'd16) ? 16 : int'(nr_in);
            m_base[u]  = state_in;
            m_cur[u]   = state_in;
            m_done[u]  = 0;
            m_phase[u] = (m_nr[u] > 0) ? 1 : 2;
          end
          1: begin
            m_done[u] = (m_done[u] + u + 1 < m_nr[u]) ? m_done[u] + u + 1 : m_nr[u];
            m_cur[u]  = model_perm(m_base[u], m_nr[u], m_done[u]);
            if (m_done[u] == m_nr[u]) m_phase[u] = 2;
          end
          default: if (out_ready) m_phase[u] = 0;
        endcase
      end
    end
    if (rst) m_live = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      for (int u = 0; u < NU; u++) begin
        chk("in_ready",  u, in_ready_w[u],  m_phase[u] == 0);
        chk("out_valid", u, out_valid_w[u], m_phase[u] == 2);
        chk("busy",      u, busy_w[u],      m_phase[u] != 0);
        chk("state_out", u, state_out_w[u], m_cur[u]);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic bit all_ready();
    bit r;
    r = 1'b1;
    for (int u = 0; u < NU; u++) if (in_ready_w[u] !== 1'b1) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!all_ready() && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 0, all_ready(), 1);
  endtask

  // Sample 1 is the first cycle after acceptance; out_valid must first show
  // after ceil(nr/UNROLL) running cycles, i.e. at sample ceil(nr/UNROLL)+1.
  task automatic send(input logic [4:0] nr, input ascon_state_t st, input int ready_pct);
    int first [NU];
    int nrc;
    bit all_seen;
    wait_idle();
    nrc = (nr > 5'd16) ? 16 : int'(nr);
    for (int u = 0; u < NU; u++) first[u] = 0;
    nr_in    = nr;
    state_in = st;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    nr_in    = 5'($urandom());
    state_in = rand_state();
    for (int k = 1; k <= 40; k++) begin
      all_seen = 1'b1;
      for (int u = 0; u < NU; u++) begin
        if (first[u] == 0 && out_valid_w[u] === 1'b1) first[u] = k;
        if (first[u] == 0) all_seen = 1'b0;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      if (all_seen) break;
      @(negedge clk);
    end
    for (int u = 0; u < NU; u++)
      chk("latency", u, first[u], (nrc + u) / (u + 1) + 1);
    txn++;
    $display("txn %0d: nr_in=%0d rounds=%0d out_valid_sample u1..u4=%0d,%0d,%0d,%0d",
             txn, nr, nrc, first[0], first[1], first[2], first[3]);
  endtask

  ascon_state_t zero_round;
  ascon_state_t pin_exp;
  ascon_state_t pattern;
  ascon_state_t st;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    nr_in     = '0;
    state_in  = '0;

    // Hand-derived single round (idx 15) on the all-zero state.
    pin_exp = {64'h000964b00000004b, 64'h0000000096000213, 64'h53ffffffffffff90,
               64'h12e580000000004b, 64'h0000000000000000};
    zero_round = model_round('0, 15);
    chk("model_pin_round15", 0, zero_round, pin_exp);

    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      chk("reset_out_valid", u, out_valid_w[u], 0);
      chk("reset_busy",      u, busy_w[u],      0);
      chk("reset_state_out", u, state_out_w[u], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < NU; u++) chk("post_reset_in_ready", u, in_ready_w[u], 1);

    // Single round on zero: must match the hand-derived value.
    send(5'd1, '0, 100);
    wait_idle();
    for (int u = 0; u < NU; u++) chk("nr1_zero_literal", u, state_out_w[u], pin_exp);

    // Zero rounds: pass-through.
    pattern = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0011223344556677,
               64'h8899aabbccddeeff, 64'h0f1e2d3c4b5a6978};
    send(5'd0, pattern, 100);
    wait_idle();
    for (int u = 0; u < NU; u++) chk("nr0_passthrough", u, state_out_w[u], pattern);

    send(5'd12, rand_state(), 100);
    send(5'd6,  rand_state(), 100);
    send(5'd8,  rand_state(), 100);
    send(5'd16, rand_state(), 100);
    send(5'd17, rand_state(), 70);
    send(5'd31, rand_state(), 70);

    // Hold the result for 5 cycles with in_valid noise; then release with in_valid high.
    send(5'd6, rand_state(), 0);
    for (int c = 0; c < 5; c++) begin
      in_valid = $urandom_range(1);
      nr_in    = 5'($urandom());
      state_in = rand_state();
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
        chk("hold_in_ready",  u, in_ready_w[u],  0);
        chk("hold_out_valid", u, out_valid_w[u], 1);
      end
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int u = 0; u < NU; u++) begin
      chk("release_in_ready",  u, in_ready_w[u],  1);
      chk("release_out_valid", u, out_valid_w[u], 0);
    end

    // Reset in the third running cycle of p12, then a p8 request.
    wait_idle();
    nr_in    = 5'd12;
    state_in = rand_state();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < NU; u++) begin
      chk("abort_out_valid", u, out_valid_w[u], 0);
      chk("abort_state_out", u, state_out_w[u], 0);
      chk("abort_in_ready",  u, in_ready_w[u],  1);
      chk("abort_busy",      u, busy_w[u],      0);
    end
    st = rand_state();
    send(5'd8, st, 100);
    wait_idle();
    for (int u = 0; u < NU; u++) chk("after_abort_p8", u, state_out_w[u], model_perm(st, 8, 8));

    for (int i = 0; i < 30; i++)
      send(5'($urandom_range(31)), rand_state(), $urandom_range(30, 100));
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
